fetch_queue: RTL and testbench

Parametrised instruction-fetch front end that replaces the fixed PC-plus-pipeline-register fetch path of the five-stage core. It owns the program counter, drives the combinational instruction ROM, and buffers fetched instructions with their addresses in a DEPTH-entry circular queue. The decoder consumes entries through a valid/ready handshake. Fetch runs ahead while decode stalls, and a redirect (jump/branch) flushes the queue in one cycle.

---
 rtl/fetch_queue.sv | 100 ++++++++++
 tb/tb_fetch_queue.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, drives the ROM and buffers fetched
// {inst, pc} pairs in a circular queue drained by the decoder.
module fetch_queue #(
  parameter int unsigned        ADDR_W     = 6,
  parameter int unsigned        INST_W     = 32,
  parameter int unsigned        DEPTH      = 4,
  parameter logic [ADDR_W-1:0]  RESET_ADDR = '0
) (
  input  logic                     clk,
  input  logic                     resetIn,
  input  logic                     enable,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirectAddr,
  output logic [ADDR_W-1:0]        romAddr,
  input  logic [INST_W-1:0]        romInst,
  input  logic                     deqReady,
  output logic                     deqValid,
  output logic [INST_W-1:0]        instOut,
  output logic [ADDR_W-1:0]        pcOut,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [ADDR_W-1:0] fetchPc, fetchPcNext;
  logic [PtrW-1:0]   wrPtr, wrPtrNext;
  logic [PtrW-1:0]   rdPtr, rdPtrNext;
  logic [CntW-1:0]   cnt, cntNext;

  logic [INST_W-1:0] instMem [DEPTH];
  logic [ADDR_W-1:0] pcMem   [DEPTH];

  logic deq;
  logic enq;

  assign full     = (cnt == CntW'(DEPTH));
  assign deqValid = (cnt != '0);
  assign count    = cnt;
  assign romAddr  = fetchPc;

  assign deq = enable & deqValid & deqReady & ~redirect;
  // A full queue still accepts a fetch when the head leaves in the same cycle.
  assign enq = enable & ~redirect & (~full | deq);

  assign instOut = deqValid ? instMem[rdPtr] : '0;
  assign pcOut   = deqValid ? pcMem[rdPtr]   : '0;

  always_comb begin
    fetchPcNext = fetchPc;
    wrPtrNext   = wrPtr;
    rdPtrNext   = rdPtr;
    cntNext     = cnt;
    if (enable) begin
      if (redirect) begin
        fetchPcNext = redirectAddr;
        wrPtrNext   = '0;
        rdPtrNext   = '0;
        cntNext     = '0;
      end else begin
        if (enq) begin
          wrPtrNext   = wrPtr + PtrW'(1);
          fetchPcNext = fetchPc + ADDR_W'(1);
        end
        if (deq) begin
          rdPtrNext = rdPtr + PtrW'(1);
        end
        if (enq && !deq) begin
          cntNext = cnt + CntW'(1);
        end else if (deq && !enq) begin
          cntNext = cnt - CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetIn) begin
    if (!resetIn) begin
      fetchPc <= RESET_ADDR;
      wrPtr   <= '0;
      rdPtr   <= '0;
      cnt     <= '0;
    end else begin
      fetchPc <= fetchPcNext;
      wrPtr   <= wrPtrNext;
      rdPtr   <= rdPtrNext;
      cnt     <= cntNext;
    end
  end

  // Storage is intentionally not reset; count gates visibility of stale entries.
  always_ff @(posedge clk) begin
    if (enq) begin
      instMem[wrPtr] <= romInst;
      pcMem[wrPtr]   <= fetchPc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed plus randomized bench for fetch_queue, checked against a queue-based
// reference model with ROM[i] = i + 100.
module tb_fetch_queue;

  localparam int unsigned       ADDR_W     = 6;
  localparam int unsigned       INST_W     = 32;
  localparam int unsigned       DEPTH      = 4;
  localparam logic [ADDR_W-1:0] RESET_ADDR = '0;
  localparam int unsigned       CNT_W      = $clog2(DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 resetIn;
  logic                 enable;
  logic                 redirect;
  logic [ADDR_W-1:0]    redirectAddr;
  logic [ADDR_W-1:0]    romAddr;
  logic [INST_W-1:0]    romInst;
  logic                 deqReady;
  logic                 deqValid;
  logic [INST_W-1:0]    instOut;
  logic [ADDR_W-1:0]    pcOut;
  logic                 full;
  logic [CNT_W-1:0]     count;

  fetch_queue #(
    .ADDR_W    (ADDR_W),
    .INST_W    (INST_W),
    .DEPTH     (DEPTH),
    .RESET_ADDR(RESET_ADDR)
  ) dut (
    .clk         (clk),
    .resetIn     (resetIn),
    .enable      (enable),
    .redirect    (redirect),
    .redirectAddr(redirectAddr),
    .romAddr     (romAddr),
    .romInst     (romInst),
    .deqReady    (deqReady),
    .deqValid    (deqValid),
    .instOut     (instOut),
    .pcOut       (pcOut),
    .full        (full),
    .count       (count)
  );

  always #5 clk = ~clk;

  assign romInst = INST_W'(romAddr) + 32'd100;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  entry_t            mq[$];
  logic [ADDR_W-1:0] mpc;
  int                nCmp = 0;
  int                nBad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nBad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutputs();
    int sz;
    sz = mq.size();
    chk("count", 64'(count), 64'(sz));
    chk("deqValid", 64'(deqValid), 64'(sz != 0));
    chk("full", 64'(full), 64'(sz == DEPTH));
    chk("romAddr", 64'(romAddr), 64'(mpc));
    chk("instOut", 64'(instOut), (sz != 0) ? 64'(mq[0].inst) : 64'd0);
    chk("pcOut", 64'(pcOut), (sz != 0) ? 64'(mq[0].pc) : 64'd0);
  endtask

  task automatic modelClock(input logic en, input logic rd, input logic [ADDR_W-1:0] addr,
                            input logic rdy);
    bit doDeq;
    bit doEnq;
    entry_t e;
    if (!en) return;
    if (rd) begin
      mq.delete();
      mpc = addr;
      return;
    end
    doDeq = rdy && (mq.size() != 0);
    doEnq = (mq.size() < DEPTH) || doDeq;
    if (doDeq) void'(mq.pop_front());
    if (doEnq) begin
      e.inst = INST_W'(mpc) + 32'd100;
      e.pc   = mpc;
      mq.push_back(e);
      mpc = mpc + 1'b1;
    end
  endtask

  // Drive inputs, check mid-cycle, advance the model over the next rising edge.
  task automatic step(input logic en, input logic rd, input logic [ADDR_W-1:0] addr,
                      input logic rdy);
    enable       = en;
    redirect     = rd;
    redirectAddr = addr;
    deqReady     = rdy;
    @(negedge clk);
    checkOutputs();
    modelClock(en, rd, addr, rdy);
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetIn      = 1'b0;
    enable       = 1'b1;
    redirect     = 1'b0;
    redirectAddr = '0;
    deqReady     = 1'b0;
    mpc          = RESET_ADDR;
    #2;
    checkOutputs();
    #5 resetIn = 1'b1;

    // Fill with decoder stalled, then hold while full.
    for (int i = 0; i < DEPTH + 3; i++) step(1'b1, 1'b0, '0, 1'b0);
    // Sustained drain at full: simultaneous enq/deq.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0, 1'b1);
    // Redirect while full with deqReady high.
    step(1'b1, 1'b1, 6'd20, 1'b1);
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b1);
    // PC wrap across 63 -> 0.
    step(1'b1, 1'b1, 6'd62, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0, 1'b1);
    // Frozen: redirect and deqReady must be ignored.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 6'd5, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, (i != 1));
    // Build count=3, then reset asynchronously between edges.
    step(1'b1, 1'b1, 6'd10, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0);
    #1 resetIn = 1'b0;
    #1;
    mq.delete();
    mpc = RESET_ADDR;
    chk("asyncRstCount", 64'(count), 64'd0);
    chk("asyncRstValid", 64'(deqValid), 64'd0);
    chk("asyncRstRomAddr", 64'(romAddr), 64'(RESET_ADDR));
    #1 resetIn = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) step(1'b1, 1'b0, '0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 11) == 0),
           ADDR_W'($urandom), ($urandom_range(0, 2) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
